// File: rtl/raster_scheduler_pkg.sv
// rtl/raster_scheduler_pkg.sv - shared raster types, scheduler state encoding and default sizing
package raster_scheduler_pkg;

   localparam int SCHED_NUM_REQ      = 4;
   localparam int SCHED_DRAIN_CYCLES = 16;
   localparam int SCHED_CNT_BITS     = 16;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
   } coord_3d_t;

   typedef struct packed {
      logic [7:0] material;
      logic [7:0] tri_id;
   } metadata_t;

   typedef enum logic [1:0] {
      SCHED_IDLE,
      SCHED_ARB,
      SCHED_DRAIN,
      SCHED_DONE
   } sched_state_t;

endpackage

// File: rtl/raster_scheduler_rr_arbiter.sv
// rtl/raster_scheduler_rr_arbiter.sv - combinational round-robin arbiter, search starts one above ptr
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx
);

   localparam int IW = $clog2(N);

   always_comb begin
      logic          found;
      logic [IW-1:0] idx;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int i = 1; i <= N; i++) begin
         idx = IW'((int'(ptr) + i) % N);
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/raster_scheduler.sv
// rtl/raster_scheduler.sv - frame sequencer and round-robin triangle dispatcher for the raster pipeline
// Define RASTER_SCHED_STATS_EN to build the raster back-pressure stall counter.
module raster_scheduler
   import raster_scheduler_pkg::*;
#(
   parameter int NUM_REQ      = SCHED_NUM_REQ,
   parameter int DRAIN_CYCLES = SCHED_DRAIN_CYCLES,
   parameter int CNT_BITS     = SCHED_CNT_BITS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      frame_start,
   input  logic [NUM_REQ-1:0]        req_vld,
   input  logic [NUM_REQ-1:0]        req_last,
   input  coord_3d_t [NUM_REQ-1:0]   req_v0,
   input  coord_3d_t [NUM_REQ-1:0]   req_v1,
   input  coord_3d_t [NUM_REQ-1:0]   req_v2,
   input  metadata_t [NUM_REQ-1:0]   req_metadata,
   output logic [NUM_REQ-1:0]        req_rdy,
   output logic                      ras_vld_in,
   output coord_3d_t                 ras_v0,
   output coord_3d_t                 ras_v1,
   output coord_3d_t                 ras_v2,
   output metadata_t                 ras_metadata,
   input  logic                      ras_rdy_in,
   input  logic                      ras_vld_out,
   output logic                      busy,
   output logic                      frame_done,
   output logic [CNT_BITS-1:0]       tri_count,
   output logic [CNT_BITS-1:0]       stall_count
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int QW = $clog2(DRAIN_CYCLES + 1);

   sched_state_t       state, state_nxt;
   logic [IW-1:0]      rr_ptr, gnt_idx;
   logic [NUM_REQ-1:0] last_seen, eligible, gnt;
   logic [QW-1:0]      quiet;
   logic               xfer, can_load, accept, quiet_cyc, start;

   assign xfer      = ras_vld_in & ras_rdy_in;
   assign can_load  = ~ras_vld_in | xfer;
   assign quiet_cyc = ~ras_vld_out & ras_rdy_in;
   assign start     = (state == SCHED_IDLE) & frame_start;
   assign eligible  = req_vld & ~last_seen;
   assign accept    = |req_rdy;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req     (eligible),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      state_nxt = state;
      req_rdy   = '0;
      case (state)
         SCHED_IDLE: begin
            if (frame_start) state_nxt = SCHED_ARB;
         end
         SCHED_ARB: begin
            if (can_load) req_rdy = gnt;
            // last_seen full means nothing is eligible, so no load races the exit
            if ((&last_seen) && can_load) state_nxt = SCHED_DRAIN;
         end
         SCHED_DRAIN: begin
            if (quiet_cyc && (quiet == QW'(DRAIN_CYCLES - 1))) state_nxt = SCHED_DONE;
         end
         SCHED_DONE: state_nxt = SCHED_IDLE;
         default:    state_nxt = SCHED_IDLE;
      endcase
   end

   assign busy       = (state != SCHED_IDLE);
   assign frame_done = (state == SCHED_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= SCHED_IDLE;
         rr_ptr       <= IW'(NUM_REQ - 1);
         last_seen    <= '0;
         quiet        <= '0;
         ras_vld_in   <= 1'b0;
         ras_v0       <= '0;
         ras_v1       <= '0;
         ras_v2       <= '0;
         ras_metadata <= '0;
         tri_count    <= '0;
      end else begin
         state <= state_nxt;

         if (start) begin
            tri_count <= '0;
            last_seen <= '0;
            quiet     <= '0;
         end else if (xfer && !(&tri_count)) begin
            tri_count <= tri_count + CNT_BITS'(1);
         end

         if (accept) begin
            ras_vld_in   <= 1'b1;
            ras_v0       <= req_v0[gnt_idx];
            ras_v1       <= req_v1[gnt_idx];
            ras_v2       <= req_v2[gnt_idx];
            ras_metadata <= req_metadata[gnt_idx];
            rr_ptr       <= gnt_idx;
            if (req_last[gnt_idx]) last_seen[gnt_idx] <= 1'b1;
         end else if (xfer) begin
            ras_vld_in <= 1'b0;
         end

         if (state == SCHED_DRAIN) begin
            quiet <= quiet_cyc ? quiet + QW'(1) : '0;
         end
      end
   end

`ifdef RASTER_SCHED_STATS_EN
   logic [CNT_BITS-1:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (start) begin
         stall_q <= '0;
      end else if ((state == SCHED_ARB || state == SCHED_DRAIN) && ras_vld_in && !ras_rdy_in
                   && !(&stall_q)) begin
         stall_q <= stall_q + CNT_BITS'(1);
      end
   end

   assign stall_count = stall_q;
`else
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_raster_scheduler.sv
// tb/tb_raster_scheduler.sv - directed table and sequence bench for raster_scheduler
module tb_raster_scheduler;
   import raster_scheduler_pkg::*;

   localparam int N = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             frame_start;
   logic [N-1:0]     req_vld, req_last, req_rdy;
   coord_3d_t [N-1:0] req_v0, req_v1, req_v2;
   metadata_t [N-1:0] req_metadata;
   logic             ras_vld_in;
   coord_3d_t        ras_v0, ras_v1, ras_v2;
   metadata_t        ras_metadata;
   logic             ras_rdy_in, ras_vld_out;
   logic             busy, frame_done;
   logic [15:0]      tri_count, stall_count;

   always #5 clk = ~clk;

   raster_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .frame_start  (frame_start),
      .req_vld      (req_vld),
      .req_last     (req_last),
      .req_v0       (req_v0),
      .req_v1       (req_v1),
      .req_v2       (req_v2),
      .req_metadata (req_metadata),
      .req_rdy      (req_rdy),
      .ras_vld_in   (ras_vld_in),
      .ras_v0       (ras_v0),
      .ras_v1       (ras_v1),
      .ras_v2       (ras_v2),
      .ras_metadata (ras_metadata),
      .ras_rdy_in   (ras_rdy_in),
      .ras_vld_out  (ras_vld_out),
      .busy         (busy),
      .frame_done   (frame_done),
      .tri_count    (tri_count),
      .stall_count  (stall_count)
   );

   typedef struct {
      logic        fs;
      logic [3:0]  vld;
      logic [3:0]  last;
      logic [3:0]  e_rdy;
      logic        e_vin;
      logic [7:0]  e_mat;
      logic        e_busy;
      logic        e_done;
      logic [15:0] e_tri;
   } vec_t;

   vec_t tbl[7];
   int   total = 0;
   int   passed = 0;
   int   n, first_x, last_x;
   int   sent[N];
   int   exp_src[8] = '{1, 3, 1, 3, 1, 3, 0, 2};
   int   exp_k[8]   = '{0, 0, 1, 1, 2, 2, 0, 0};
   metadata_t got[$];
   metadata_t m;
   logic [N-1:0] acc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      else passed++;
   endtask

   function automatic coord_3d_t mk(input int i, input int k, input int v);
      return '{x: 16'(i * 256 + k), y: 16'(v * 16 + k), z: 16'(i + k + v)};
   endfunction

   task automatic set_req_data(input int i, input int k);
      req_v0[i]       = mk(i, k, 0);
      req_v1[i]       = mk(i, k, 1);
      req_v2[i]       = mk(i, k, 2);
      req_metadata[i] = '{material: 8'(i + 1), tri_id: 8'(k)};
   endtask

   task automatic wait_done(output int cnt);
      cnt = 0;
      while (!frame_done && cnt < 300) begin
         @(negedge clk); #1;
         cnt++;
      end
   endtask

   task automatic finish_frame(output int cnt);
      logic [N-1:0] a;
      a = req_vld & req_rdy;
      cnt = 0;
      while (!frame_done && cnt < 300) begin
         @(negedge clk);
         req_vld = req_vld & ~a;
         #1;
         a = req_vld & req_rdy;
         cnt++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b1, 4'hF, 4'hF, 4'b0000, 1'b0, 8'd0, 1'b0, 1'b0, 16'd0};
      tbl[1] = '{1'b0, 4'hF, 4'hF, 4'b0001, 1'b0, 8'd0, 1'b1, 1'b0, 16'd0};
      tbl[2] = '{1'b0, 4'hF, 4'hF, 4'b0010, 1'b1, 8'd1, 1'b1, 1'b0, 16'd0};
      tbl[3] = '{1'b0, 4'hF, 4'hF, 4'b0100, 1'b1, 8'd2, 1'b1, 1'b0, 16'd1};
      tbl[4] = '{1'b0, 4'hF, 4'hF, 4'b1000, 1'b1, 8'd3, 1'b1, 1'b0, 16'd2};
      tbl[5] = '{1'b0, 4'hF, 4'hF, 4'b0000, 1'b1, 8'd4, 1'b1, 1'b0, 16'd3};
      tbl[6] = '{1'b0, 4'hF, 4'hF, 4'b0000, 1'b0, 8'd4, 1'b1, 1'b0, 16'd4};

      rst = 1'b1; frame_start = 1'b0; req_vld = '0; req_last = '0;
      ras_rdy_in = 1'b1; ras_vld_out = 1'b0;
      for (int i = 0; i < N; i++) set_req_data(i, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_req_rdy", req_rdy, 0);
      check("rst_vld_in", ras_vld_in, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_tri", tri_count, 0);
      check("rst_stall", stall_count, 0);

      // frame 1: all four send one last triangle
      for (int r = 0; r < 7; r++) begin
         @(negedge clk);
         frame_start = tbl[r].fs; req_vld = tbl[r].vld; req_last = tbl[r].last;
         #1;
         check($sformatf("f1_rdy[%0d]", r), req_rdy, tbl[r].e_rdy);
         check($sformatf("f1_vin[%0d]", r), ras_vld_in, tbl[r].e_vin);
         check($sformatf("f1_mat[%0d]", r), ras_metadata.material, tbl[r].e_mat);
         check($sformatf("f1_busy[%0d]", r), busy, tbl[r].e_busy);
         check($sformatf("f1_done[%0d]", r), frame_done, tbl[r].e_done);
         check($sformatf("f1_tri[%0d]", r), tri_count, tbl[r].e_tri);
      end
      wait_done(n);
      check("f1_drain_len", n, 16);
      check("f1_tri_final", tri_count, 4);
      @(negedge clk); #1;
      check("f1_done_pulse", frame_done, 0);
      check("f1_idle", busy, 0);

      // frame 2: requesters 1 and 3 stream three each, then 0 and 2 close out
      @(negedge clk);
      frame_start = 1'b1; req_vld = '0; #1;
      for (int i = 0; i < N; i++) sent[i] = 0;
      got.delete(); first_x = -1; last_x = -1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         frame_start = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (i == 1 || i == 3) begin
               req_vld[i]  = (sent[i] < 3);
               req_last[i] = (sent[i] == 2);
            end else begin
               req_vld[i]  = (sent[1] == 3 && sent[3] == 3 && sent[i] < 1);
               req_last[i] = 1'b1;
            end
            set_req_data(i, sent[i]);
         end
         #1;
         if (ras_vld_in && ras_rdy_in) begin
            got.push_back(ras_metadata);
            if (first_x < 0) first_x = c;
            last_x = c;
         end
         for (int i = 0; i < N; i++) if (req_vld[i] && req_rdy[i]) sent[i]++;
         if (frame_done) break;
      end
      check("f2_done", frame_done, 1);
      check("f2_count", got.size(), 8);
      for (int k = 0; k < 8; k++) begin
         m = (k < got.size()) ? got[k] : '0;
         check($sformatf("f2_order[%0d]", k), m, {8'(exp_src[k] + 1), 8'(exp_k[k])});
      end
      check("f2_no_bubble", last_x - first_x, 7);
      check("f2_tri", tri_count, 8);
      @(negedge clk); #1;

      // frame 3: raster back-pressure for five cycles
      @(negedge clk);
      frame_start = 1'b1; req_vld = '0; #1;
      @(negedge clk);
      frame_start = 1'b0; req_vld = 4'b0001; req_last = 4'b0000; set_req_data(0, 5); #1;
      check("f3_load", req_rdy, 4'b0001);
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         ras_rdy_in = 1'b0; set_req_data(0, 6); #1;
         check($sformatf("f3_stall_rdy[%0d]", s), req_rdy, 0);
         check($sformatf("f3_stall_vin[%0d]", s), ras_vld_in, 1);
         check($sformatf("f3_stall_meta[%0d]", s), ras_metadata.tri_id, 5);
         check($sformatf("f3_stall_v0[%0d]", s), ras_v0, mk(0, 5, 0));
      end
      @(negedge clk);
      ras_rdy_in = 1'b1; req_vld = 4'hF; req_last = 4'hF;
      for (int i = 1; i < N; i++) set_req_data(i, 7);
      #1;
      check("f3_resume_gnt", req_rdy, 4'b0010);
      finish_frame(n);
      check("f3_done", frame_done, 1);
      check("f3_tri", tri_count, 5);
`ifdef RASTER_SCHED_STATS_EN
      check("f3_stall_count", stall_count, 5);
`else
      check("f3_stall_count", stall_count, 0);
`endif
      @(negedge clk); #1;

      // frame 4: requester 2 retries after its last, then a drain restart
      @(negedge clk);
      frame_start = 1'b1; req_vld = '0; #1;
      @(negedge clk);
      frame_start = 1'b0; req_vld = 4'b0100; req_last = 4'b0100; set_req_data(2, 0); #1;
      check("f4_gnt2", req_rdy, 4'b0100);
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         req_last = 4'b0000; set_req_data(2, 1); #1;
         check($sformatf("f4_after_last[%0d]", s), req_rdy, 0);
      end
      check("f4_tri_hold", tri_count, 1);
      @(negedge clk);
      req_vld = 4'b1011; req_last = 4'b1011;
      for (int i = 0; i < N; i++) if (i != 2) set_req_data(i, 0);
      #1;
      acc = req_vld & req_rdy;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         req_vld = req_vld & ~acc; #1;
         acc = req_vld & req_rdy;
         if (req_vld == '0 && !ras_vld_in) break;
      end
      check("f4_tri", tri_count, 4);
      check("f4_drain_busy", busy, 1);
      repeat (9) begin @(negedge clk); #1; end
      @(negedge clk);
      ras_vld_out = 1'b1; frame_start = 1'b1; #1;
      check("f4_pulse_busy", busy, 1);
      check("f4_pulse_done", frame_done, 0);
      @(negedge clk);
      ras_vld_out = 1'b0; frame_start = 1'b0; #1;
      wait_done(n);
      check("f4_drain_restart", n, 16);
      check("f4_tri_final", tri_count, 4);
      @(negedge clk); #1;
      check("f4_start_ignored", busy, 0);

      // frame 5: reset while the out-register is full
      @(negedge clk);
      frame_start = 1'b1; req_vld = '0; #1;
      @(negedge clk);
      frame_start = 1'b0; req_vld = 4'b0001; req_last = 4'b0000; set_req_data(0, 0); #1;
      @(negedge clk);
      set_req_data(0, 1); #1;
      @(negedge clk);
      req_vld = '0; ras_rdy_in = 1'b0; rst = 1'b1; #1;
      check("f5_pre_vin", ras_vld_in, 1);
      check("f5_pre_tri", tri_count, 1);
      @(negedge clk);
      rst = 1'b0; ras_rdy_in = 1'b1; #1;
      check("f5_rst_vin", ras_vld_in, 0);
      check("f5_rst_busy", busy, 0);
      check("f5_rst_tri", tri_count, 0);
      @(negedge clk);
      frame_start = 1'b1; req_vld = 4'hF; req_last = 4'hF;
      for (int i = 0; i < N; i++) set_req_data(i, 0);
      #1;
      @(negedge clk);
      frame_start = 1'b0; #1;
      check("f5_first_gnt", req_rdy, 4'b0001);
      finish_frame(n);
      check("f5_done", frame_done, 1);
      check("f5_tri", tri_count, 4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
